// File: rtl/twiddle_mult_stage2_if.sv
// Complex sample stream (valid, start-of-frame, real/imaginary) between FFT stages.
// The master drives the stream; the slave consumes it.
interface twiddle_mult_stage2_if #(
  parameter int DATA_W = 16
);
  logic                     valid;
  logic                     sof;
  logic signed [DATA_W-1:0] re;
  logic signed [DATA_W-1:0] im;

  modport master (output valid, sof, re, im);
  modport slave  (input  valid, sof, re, im);
endinterface

// File: rtl/twiddle_mult_stage2.sv
// Stage-2 twiddle multiplier of the 256-point FFT: indexes the twiddle ROM per sample,
// does the complex multiply, rounds/saturates, and forwards with valid/sof (latency 3).
module twiddle_mult_stage2 #(
  parameter int N      = 256,
  parameter int SIZE   = 8,
  parameter int DATA_W = 16,
  parameter int TW_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  twiddle_mult_stage2_if.slave   in_if,
  twiddle_mult_stage2_if.master  out_if,
  output logic [SIZE-4:0]        rd_ptr_angle,
  output logic                   tw_en,
  input  logic signed [TW_W-1:0] cos_data,
  input  logic signed [TW_W-1:0] sin_data
);

  localparam int PW   = DATA_W + TW_W;
  localparam int SW   = PW + 1;
  localparam int FRAC = TW_W - 2;
  localparam logic signed [SW-1:0] RND     = SW'(1 << (FRAC - 1));
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SW'(2 ** (DATA_W - 1));

  function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] v);
    return (v + RND) >>> FRAC;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] idx;

  // A start-of-frame sample always takes index 0; N is a power of two so cnt wraps by overflow.
  assign idx          = in_if.sof ? '0 : cnt;
  assign rd_ptr_angle = (idx[1:0] == 2'b11) ? {{(SIZE-4){1'b0}}, 1'b1} : '0;
  assign tw_en        = in_if.valid;

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (in_if.valid) cnt <= idx + {{(SIZE-1){1'b0}}, 1'b1};
  end

  // ---- p1: data waits one cycle for the registered ROM twiddle
  logic                     vld_p1, sof_p1;
  logic signed [DATA_W-1:0] xr_p1, xi_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_if.valid;
      sof_p1 <= in_if.valid & in_if.sof;
    end
  end

  always_ff @(posedge clk) begin
    xr_p1 <= in_if.re;
    xi_p1 <= in_if.im;
  end

  // ---- p2: four full-precision partial products
  logic                 vld_p2, sof_p2;
  logic signed [PW-1:0] rc_p2, is_p2, rs_p2, ic_p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      sof_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      sof_p2 <= sof_p1;
    end
  end

  always_ff @(posedge clk) begin
    rc_p2 <= PW'(xr_p1) * PW'(cos_data);
    is_p2 <= PW'(xi_p1) * PW'(sin_data);
    rs_p2 <= PW'(xr_p1) * PW'(sin_data);
    ic_p2 <= PW'(xi_p1) * PW'(cos_data);
  end

  // ---- p3: combine, round half-up, saturate, register output
  logic signed [SW-1:0] re_sum, im_sum;

  always_comb begin
    re_sum = SW'(rc_p2) - SW'(is_p2);
    im_sum = SW'(rs_p2) + SW'(ic_p2);
  end

  // Output data is cleared by reset too; between valid results it holds the last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_if.valid <= 1'b0;
      out_if.sof   <= 1'b0;
      out_if.re    <= '0;
      out_if.im    <= '0;
    end else begin
      out_if.valid <= vld_p2;
      out_if.sof   <= sof_p2;
      if (vld_p2) begin
        out_if.re <= saturate(round_shift(re_sum));
        out_if.im <= saturate(round_shift(im_sum));
      end
    end
  end

endmodule
